// File: rtl/bpu_pkg.sv
// Shared types and helpers for the branch resolution path.
package bpu_pkg;

    localparam int unsigned PC_W   = 8;
    localparam int unsigned FLAG_W = 5;

    // Bit positions inside the {pf,sf,of,zf,cf} ALU flag vector
    localparam int unsigned FLAG_CF = 0;
    localparam int unsigned FLAG_ZF = 1;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_SF = 3;
    localparam int unsigned FLAG_PF = 4;

    typedef enum logic [3:0] {
        COND_ALWAYS  = 4'd0,
        COND_Z       = 4'd1,
        COND_NZ      = 4'd2,
        COND_C       = 4'd3,
        COND_NC      = 4'd4,
        COND_S       = 4'd5,
        COND_NS      = 4'd6,
        COND_O       = 4'd7,
        COND_NO      = 4'd8,
        COND_P       = 4'd9,
        COND_NP      = 4'd10,
        COND_LT      = 4'd11,
        COND_GT      = 4'd12,
        COND_NEVER_D = 4'd13,
        COND_NEVER_E = 4'd14,
        COND_NEVER_F = 4'd15
    } cond_e;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] target;
        logic            taken;
    } pred_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } bru_state_e;

    // Real branch outcome for a condition code given the ALU flags
    function automatic logic cond_eval(input cond_e c, input logic [FLAG_W-1:0] f);
        logic zf, cf, sf, of, pf;
        zf = f[FLAG_ZF];
        cf = f[FLAG_CF];
        sf = f[FLAG_SF];
        of = f[FLAG_OF];
        pf = f[FLAG_PF];
        case (c)
            COND_ALWAYS: return 1'b1;
            COND_Z:      return zf;
            COND_NZ:     return ~zf;
            COND_C:      return cf;
            COND_NC:     return ~cf;
            COND_S:      return sf;
            COND_NS:     return ~sf;
            COND_O:      return of;
            COND_NO:     return ~of;
            COND_P:      return pf;
            COND_NP:     return ~pf;
            COND_LT:     return sf ^ of;
            COND_GT:     return ~(sf ^ of) & ~zf;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/bpu_pred_fifo.sv
// In-order store of outstanding predictions; clear wins over push/pop.
module bpu_pred_fifo
    import bpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_i,
    input  pred_entry_t push_data_i,
    input  logic        pop_i,
    input  logic        clear_i,
    output pred_entry_t head_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    pred_entry_t        mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (count == CNT_W'(DEPTH));
    assign empty_o = (count == '0);
    assign head_o  = mem[rd_ptr];

    // A pop frees a slot in the same cycle, so push is allowed at full when popping
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    // Pointer and occupancy tracking
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until pushed
    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) mem[wr_ptr] <= push_data_i;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Retires predicted branches in order, reports outcomes and flushes on mispredicts.
module branch_resolve_unit
    import bpu_pkg::*;
#(
    parameter int unsigned STEP_NUM   = 4,
    parameter int unsigned ADDR_WIDTH = PC_W
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  pred_valid_i,
    input  logic                  pred_taken_i,
    input  logic [ADDR_WIDTH-1:0] pred_pc_i,
    input  logic [ADDR_WIDTH-1:0] pred_target_i,
    output logic                  pred_ready_o,
    input  logic                  res_valid_i,
    input  logic [3:0]            res_cond_i,
    input  logic [4:0]            flags_i,
    output logic                  conditional_jump_o,
    output logic                  shouldnt_jump_o,
    output logic                  upd_valid_o,
    output logic [ADDR_WIDTH-1:0] upd_pc_o,
    output logic                  flush_o,
    output logic [ADDR_WIDTH-1:0] redirect_pc_o,
    output logic                  underflow_o,
    output logic [15:0]           branch_cnt_o,
    output logic [15:0]           mispred_cnt_o
);

    bru_state_e  state_q;
    bru_state_e  state_d;
    pred_entry_t head;
    pred_entry_t push_entry;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_push;
    logic        resolve;
    logic        underflow_hit;
    logic        actual;
    logic        mispredict;

    assign push_entry = '{pc: pred_pc_i, target: pred_target_i, taken: pred_taken_i};

    bpu_pred_fifo #(
        .DEPTH (STEP_NUM)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (resolve),
        .clear_i     (mispredict),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign actual     = cond_eval(cond_e'(res_cond_i), flags_i);
    assign mispredict = resolve & (actual != head.taken);
    // A prediction arriving alongside a mispredict is younger than the fault and is dropped
    assign fifo_push  = pred_valid_i & pred_ready_o & ~mispredict;

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= RUN;
        else         state_q <= state_d;
    end

    // Next-state: a mispredict costs exactly one flush cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (mispredict) state_d = FLUSH;
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Per-state handshake and resolve qualification
    always_comb begin
        pred_ready_o  = 1'b0;
        resolve       = 1'b0;
        underflow_hit = 1'b0;
        case (state_q)
            RUN: begin
                pred_ready_o  = rst_ni & ~fifo_full;
                resolve       = res_valid_i & ~fifo_empty;
                underflow_hit = res_valid_i & fifo_empty;
            end
            default: ;
        endcase
    end

    // Registered resolution results, pulses valid for one cycle after resolve
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            conditional_jump_o <= 1'b0;
            shouldnt_jump_o    <= 1'b0;
            upd_valid_o        <= 1'b0;
            upd_pc_o           <= '0;
            flush_o            <= 1'b0;
            redirect_pc_o      <= '0;
            underflow_o        <= 1'b0;
            branch_cnt_o       <= '0;
            mispred_cnt_o      <= '0;
        end else begin
            upd_valid_o        <= resolve;
            conditional_jump_o <= resolve & actual;
            shouldnt_jump_o    <= resolve & head.taken & ~actual;
            flush_o            <= mispredict;
            if (resolve) begin
                upd_pc_o     <= head.pc;
                branch_cnt_o <= branch_cnt_o + 16'd1;
            end
            if (mispredict) begin
                redirect_pc_o <= actual ? head.target : head.pc + ADDR_WIDTH'(1);
                mispred_cnt_o <= mispred_cnt_o + 16'd1;
            end
            if (underflow_hit) underflow_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit with a queue-based reference model.
module tb_branch_resolve_unit;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       pred_valid_i;
    logic       pred_taken_i;
    logic [7:0] pred_pc_i;
    logic [7:0] pred_target_i;
    logic       pred_ready_o;
    logic       res_valid_i;
    logic [3:0] res_cond_i;
    logic [4:0] flags_i;
    logic       conditional_jump_o;
    logic       shouldnt_jump_o;
    logic       upd_valid_o;
    logic [7:0] upd_pc_o;
    logic       flush_o;
    logic [7:0] redirect_pc_o;
    logic       underflow_o;
    logic [15:0] branch_cnt_o;
    logic [15:0] mispred_cnt_o;

    always #5 clk = ~clk;

    branch_resolve_unit #(.STEP_NUM(4), .ADDR_WIDTH(8)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .pred_valid_i       (pred_valid_i),
        .pred_taken_i       (pred_taken_i),
        .pred_pc_i          (pred_pc_i),
        .pred_target_i      (pred_target_i),
        .pred_ready_o       (pred_ready_o),
        .res_valid_i        (res_valid_i),
        .res_cond_i         (res_cond_i),
        .flags_i            (flags_i),
        .conditional_jump_o (conditional_jump_o),
        .shouldnt_jump_o    (shouldnt_jump_o),
        .upd_valid_o        (upd_valid_o),
        .upd_pc_o           (upd_pc_o),
        .flush_o            (flush_o),
        .redirect_pc_o      (redirect_pc_o),
        .underflow_o        (underflow_o),
        .branch_cnt_o       (branch_cnt_o),
        .mispred_cnt_o      (mispred_cnt_o)
    );

    typedef struct {
        logic [7:0] pc;
        logic [7:0] tgt;
        logic       taken;
    } ent_t;

    typedef struct {
        logic [7:0] pc;
        logic       jump;
        logic       sj;
        logic       flush;
        logic [7:0] redir;
    } exp_t;

    ent_t  m_q[$];
    exp_t  exp_q[$];
    logic  m_flush   = 1'b0;
    logic  m_under   = 1'b0;
    logic  m_was_rst = 1'b0;
    int    m_bcnt    = 0;
    int    m_mcnt    = 0;
    int    n_checks  = 0;
    int    n_fail    = 0;
    logic  done      = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Architectural branch condition, written from the condition table
    function automatic logic ref_cond(input logic [3:0] c, input logic [4:0] fl);
        logic pf, sf, of, zf, cf;
        {pf, sf, of, zf, cf} = fl;
        case (c)
            4'd0:    return 1'b1;
            4'd1:    return zf;
            4'd2:    return !zf;
            4'd3:    return cf;
            4'd4:    return !cf;
            4'd5:    return sf;
            4'd6:    return !sf;
            4'd7:    return of;
            4'd8:    return !of;
            4'd9:    return pf;
            4'd10:   return !pf;
            4'd11:   return sf != of;
            4'd12:   return (sf == of) && !zf;
            default: return 1'b0;
        endcase
    endfunction

    // One clock of stimulus; model advances at the edge, checks at the negedge
    task automatic step(input logic pv, input logic pt, input logic [7:0] ppc, input logic [7:0] ptg,
                        input logic rv, input logic [3:0] rc, input logic [4:0] fl, input logic rn,
                        output logic acc);
        logic  rdy;
        logic  mis;
        logic  act;
        logic  nf;
        ent_t  h;
        exp_t  e;
        pred_valid_i  = pv;
        pred_taken_i  = pt;
        pred_pc_i     = ppc;
        pred_target_i = ptg;
        res_valid_i   = rv;
        res_cond_i    = rc;
        flags_i       = fl;
        rst_ni        = rn;
        @(negedge clk);
        rdy = rn && !m_flush && (m_q.size() < 4);
        chk("pred_ready", 32'(pred_ready_o), 32'(rdy));
        chk("branch_cnt", 32'(branch_cnt_o), 32'(m_bcnt[15:0]));
        chk("mispred_cnt", 32'(mispred_cnt_o), 32'(m_mcnt[15:0]));
        chk("underflow", 32'(underflow_o), 32'(m_under));
        if (m_was_rst) begin
            chk("rst_upd_pc", 32'(upd_pc_o), 32'd0);
            chk("rst_redirect", 32'(redirect_pc_o), 32'd0);
            chk("rst_pulses", 32'({upd_valid_o, flush_o, conditional_jump_o, shouldnt_jump_o}), 32'd0);
        end
        @(posedge clk);
        acc = 1'b0;
        if (!rn) begin
            m_q.delete();
            m_flush   = 1'b0;
            m_under   = 1'b0;
            m_bcnt    = 0;
            m_mcnt    = 0;
            m_was_rst = 1'b1;
        end else begin
            m_was_rst = 1'b0;
            mis = 1'b0;
            nf  = 1'b0;
            if (!m_flush && rv) begin
                if (m_q.size() == 0) begin
                    m_under = 1'b1;
                end else begin
                    h       = m_q.pop_front();
                    act     = ref_cond(rc, fl);
                    mis     = (act != h.taken);
                    e.pc    = h.pc;
                    e.jump  = act;
                    e.sj    = h.taken && !act;
                    e.flush = mis;
                    e.redir = act ? h.tgt : h.pc + 8'd1;
                    exp_q.push_back(e);
                    m_bcnt = (m_bcnt + 1) % 65536;
                    if (mis) begin
                        m_mcnt = (m_mcnt + 1) % 65536;
                        m_q.delete();
                        nf = 1'b1;
                    end
                end
            end
            acc = pv && rdy;
            if (acc && !mis) m_q.push_back('{pc: ppc, tgt: ptg, taken: pt});
            m_flush = nf;
        end
        #1;
    endtask

    // Monitor: every DUT update pulse must match the oldest expected outcome
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) break;
            if (upd_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_upd", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("upd_pc", 32'(upd_pc_o), 32'(e.pc));
                    chk("cond_jump", 32'(conditional_jump_o), 32'(e.jump));
                    chk("shouldnt_jump", 32'(shouldnt_jump_o), 32'(e.sj));
                    chk("flush", 32'(flush_o), 32'(e.flush));
                    if (e.flush) chk("redirect_pc", 32'(redirect_pc_o), 32'(e.redir));
                end
            end else begin
                chk("idle_pulses", 32'({conditional_jump_o, shouldnt_jump_o, flush_o}), 32'd0);
            end
        end
    end

    initial begin
        logic       a;
        logic       pend_v;
        logic       pend_t;
        logic [7:0] pend_pc;
        logic [7:0] pend_tg;
        logic       rv;
        logic       rn;

        // Reset and idle
        step(0, 0, 8'h00, 8'h00, 0, 4'd0, 5'd0, 0, a);
        step(0, 0, 8'h00, 8'h00, 1, 4'd0, 5'd0, 0, a);
        step(0, 0, 8'h00, 8'h00, 0, 4'd0, 5'd0, 1, a);

        // Correct taken prediction
        step(1, 1, 8'h10, 8'h40, 0, 4'd0, 5'd0, 1, a);
        step(0, 0, 8'h00, 8'h00, 1, 4'd1, 5'b00010, 1, a);
        step(0, 0, 8'h00, 8'h00, 0, 4'd0, 5'd0, 1, a);

        // Taken mispredict with a younger entry behind it
        step(1, 1, 8'h20, 8'h80, 0, 4'd0, 5'd0, 1, a);
        step(1, 0, 8'h21, 8'h90, 0, 4'd0, 5'd0, 1, a);
        step(1, 1, 8'h55, 8'h66, 1, 4'd2, 5'b00010, 1, a);
        step(1, 1, 8'h55, 8'h66, 1, 4'd0, 5'd0, 1, a);
        step(0, 0, 8'h00, 8'h00, 0, 4'd0, 5'd0, 1, a);

        // Not-taken mispredict on the top address
        step(1, 0, 8'hFF, 8'h05, 0, 4'd0, 5'd0, 1, a);
        step(0, 0, 8'h00, 8'h00, 1, 4'd0, 5'd0, 1, a);
        step(0, 0, 8'h00, 8'h00, 0, 4'd0, 5'd0, 1, a);

        // Fill, then push held against a full FIFO while draining in order
        for (int i = 0; i < 4; i++)
            step(1, 0, 8'(8'h30 + i), 8'(8'hA0 + i), 0, 4'd0, 5'd0, 1, a);
        step(1, 1, 8'h34, 8'hB4, 0, 4'd0, 5'd0, 1, a);
        step(1, 1, 8'h34, 8'hB4, 1, 4'd13, 5'd0, 1, a);
        step(1, 1, 8'h34, 8'hB4, 0, 4'd0, 5'd0, 1, a);
        step(1, 1, 8'h35, 8'hB5, 1, 4'd4, 5'b00001, 1, a);
        for (int i = 0; i < 3; i++)
            step(0, 0, 8'h00, 8'h00, 1, 4'd14, 5'd0, 1, a);
        step(0, 0, 8'h00, 8'h00, 1, 4'd0, 5'd0, 1, a);
        step(0, 0, 8'h00, 8'h00, 0, 4'd0, 5'd0, 1, a);

        // Resolve with nothing outstanding
        step(0, 0, 8'h00, 8'h00, 1, 4'd0, 5'd0, 1, a);
        step(0, 0, 8'h00, 8'h00, 0, 4'd0, 5'd0, 1, a);

        // Reset with three entries queued
        for (int i = 0; i < 3; i++)
            step(1, 1, 8'(8'h70 + i), 8'h00, 0, 4'd0, 5'd0, 1, a);
        step(0, 0, 8'h00, 8'h00, 1, 4'd0, 5'd0, 0, a);
        step(1, 0, 8'h00, 8'h00, 1, 4'd0, 5'd0, 0, a);
        for (int i = 0; i < 3; i++)
            step(0, 0, 8'h00, 8'h00, 0, 4'd0, 5'd0, 1, a);

        // Randomized traffic with a held-until-accepted source
        pend_v  = 1'b0;
        pend_t  = 1'b0;
        pend_pc = '0;
        pend_tg = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!pend_v && $urandom_range(0, 99) < 60) begin
                pend_v  = 1'b1;
                pend_t  = 1'($urandom);
                pend_pc = 8'($urandom);
                pend_tg = 8'($urandom);
            end
            rv = ($urandom_range(0, 99) < 45);
            rn = ($urandom_range(0, 299) != 0);
            step(pend_v, pend_t, pend_pc, pend_tg, rv, 4'($urandom), 5'($urandom), rn, a);
            if (a || !rn) pend_v = 1'b0;
        end

        step(0, 0, 8'h00, 8'h00, 0, 4'd0, 5'd0, 1, a);
        step(0, 0, 8'h00, 8'h00, 0, 4'd0, 5'd0, 1, a);
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
